// File: rtl/nn_pkg.sv
// Shared sizing for the conv1 -> pool1 slice of the network.
// Holds the conv1 output frame geometry, the pooled frame geometry, the conv1
// channel count, and the counter/address widths derived from them.
// No ports: package only.
package nn_pkg;

    // Width of a counter/index that must hold 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CONV1_OUT_W = 26;
    localparam int CONV1_OUT_H = 26;
    localparam int POOL1_OUT_W = CONV1_OUT_W / 2;
    localparam int POOL1_OUT_H = CONV1_OUT_H / 2;
    localparam int NUM_CH1     = 8;

    localparam int CONV1_COL_W  = cnt_w(CONV1_OUT_W);
    localparam int CONV1_ROW_W  = cnt_w(CONV1_OUT_H);
    localparam int POOL1_ADDR_W = cnt_w(POOL1_OUT_W);

endpackage

// File: rtl/pool1_line_buf.sv
// Line buffer for 2x2 max pooling: holds the horizontally pooled pairs of the
// current even input row until the matching odd row arrives.
// Ports:
//   clk, rst  - clock, synchronous active-high clear of every entry
//   we        - write enable
//   waddr     - write entry index (pooled column)
//   wdata     - write data (all channels)
//   raddr     - read entry index (pooled column)
//   rdata     - combinational read data
module pool1_line_buf
    import nn_pkg::*;
#(
    parameter int DEPTH = POOL1_OUT_W,
    parameter int WIDTH = NUM_CH1,
    localparam int AW   = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool_layer_1.sv
// 2x2 stride-2 max pooling of the binary conv1 stream. With 1-bit channels the
// max of a 2x2 window is the OR of its four pixels, so each even row stores the
// OR of horizontal pairs in a line buffer and the odd row finishes the window.
// Trailing odd column/row (floor pooling) is counted but never pooled.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   conv1_in         - one bit per channel for the current input beat
//   valid_in         - input beat qualifier; gaps freeze all state
//   pool1_out        - registered pooled pixel, held between pulses
//   valid_out_pool1  - one-cycle pulse per pooled pixel
//   frame_done       - pulse coincident with the last pooled pixel of a frame
module maxpool_layer_1
    import nn_pkg::*;
#(
    parameter int IN_WIDTH  = CONV1_OUT_W,
    parameter int IN_HEIGHT = CONV1_OUT_H,
    parameter int CHANNELS  = NUM_CH1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] conv1_in,
    input  logic                valid_in,
    output logic [CHANNELS-1:0] pool1_out,
    output logic                valid_out_pool1,
    output logic                frame_done
);

    localparam int CW    = cnt_w(IN_WIDTH);
    localparam int RW    = cnt_w(IN_HEIGHT);
    localparam int OUT_W = IN_WIDTH / 2;
    localparam int OUT_H = IN_HEIGHT / 2;
    localparam int AW    = cnt_w(OUT_W);

    localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_HEIGHT - 1);
    // Input position whose window completes the last pooled pixel of the frame.
    localparam logic [CW-1:0] COL_FINAL = CW'(2 * OUT_W - 1);
    localparam logic [RW-1:0] ROW_FINAL = RW'(2 * OUT_H - 1);

    logic [CW-1:0]       col_cnt;
    logic [RW-1:0]       row_cnt;
    logic [CHANNELS-1:0] hold;
    logic [CHANNELS-1:0] lb_rdata;
    logic [AW-1:0]       lb_addr;
    logic                odd_col;
    logic                odd_row;
    logic                in_pool;
    logic                lb_we;
    logic                last_pair;

    assign odd_col   = col_cnt[0];
    assign odd_row   = row_cnt[0];
    // Only beats inside the 2*OUT_W x 2*OUT_H area take part in pooling.
    assign in_pool   = (int'(col_cnt) < 2 * OUT_W) && (int'(row_cnt) < 2 * OUT_H);
    assign lb_addr   = AW'(col_cnt >> 1);
    assign lb_we     = valid_in && in_pool && odd_col && !odd_row;
    assign last_pair = (col_cnt == COL_FINAL) && (row_cnt == ROW_FINAL);

    pool1_line_buf #(
        .DEPTH (OUT_W),
        .WIDTH (CHANNELS)
    ) u_line_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (hold | conv1_in),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt         <= '0;
            row_cnt         <= '0;
            hold            <= '0;
            pool1_out       <= '0;
            valid_out_pool1 <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            valid_out_pool1 <= 1'b0;
            frame_done      <= 1'b0;
            if (valid_in) begin
                if (col_cnt == COL_LAST) begin
                    col_cnt <= '0;
                    row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
                // Even column opens a horizontal pair on either row parity.
                if (in_pool && !odd_col) begin
                    hold <= conv1_in;
                end
                // Odd row, odd column closes the 2x2 window.
                if (in_pool && odd_col && odd_row) begin
                    pool1_out       <= lb_rdata | hold | conv1_in;
                    valid_out_pool1 <= 1'b1;
                    frame_done      <= last_pair;
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool_layer_1.sv
// Bench for maxpool_layer_1: a 26x26 instance (a) and a 5x5 instance (b).
// Expected pooled pixels are computed from the stimulus image and queued when
// the closing odd/odd beat is driven; they must appear exactly one clock later.
module tb_maxpool_layer_1;

    localparam int W = 26, H = 26;
    localparam int SW = 5, SH = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] a_in, b_in;
    logic       a_v, b_v;
    logic [7:0] a_out, b_out;
    logic       a_vo, b_vo, a_fd, b_fd;

    maxpool_layer_1 #(.IN_WIDTH(W), .IN_HEIGHT(H), .CHANNELS(8)) dut_a (
        .clk(clk), .rst(rst), .conv1_in(a_in), .valid_in(a_v),
        .pool1_out(a_out), .valid_out_pool1(a_vo), .frame_done(a_fd)
    );

    maxpool_layer_1 #(.IN_WIDTH(SW), .IN_HEIGHT(SH), .CHANNELS(8)) dut_b (
        .clk(clk), .rst(rst), .conv1_in(b_in), .valid_in(b_v),
        .pool1_out(b_out), .valid_out_pool1(b_vo), .frame_done(b_fd)
    );

    typedef struct {
        logic [7:0] data;
        logic       done;
    } exp_t;

    typedef struct {
        int         hr;
        int         hc;
        int         hch;
        int         pr;
        int         pc;
        logic [7:0] exp;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    bit   pend_a, pend_b;
    logic [7:0] last_a, last_b;
    int   vectors = 0;
    int   miscompares = 0;
    int   pulses_a, pulses_b, dones_a, dones_b;
    int   cap_idx;
    logic [7:0] cap_val;
    vec_t tbl[5];

    // Image modes: 0 = zero frame with one hot bit, 1 = all ones, 2 = checkerboard on channel 3.
    function automatic logic [7:0] pix(int mode, int hr, int hc, int hch, int r, int c);
        logic [7:0] one;
        one = 8'h01;
        case (mode)
            0:       return (r == hr && c == hc) ? (one << hch) : 8'h00;
            1:       return 8'hFF;
            default: return ((r + c) % 2 == 1) ? 8'h08 : 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] pooled(int mode, int hr, int hc, int hch, int pr, int pc);
        return pix(mode, hr, hc, hch, 2*pr, 2*pc)   | pix(mode, hr, hc, hch, 2*pr, 2*pc+1) |
               pix(mode, hr, hc, hch, 2*pr+1, 2*pc) | pix(mode, hr, hc, hch, 2*pr+1, 2*pc+1);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock: sample both DUTs #1 after the edge, then return inputs to idle.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (rst) begin
            last_a = 8'h00;
            last_b = 8'h00;
        end
        if (pend_a) begin
            chk("a_valid", a_vo, 1);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_data", a_out, e.data);
                chk("a_done", a_fd, e.done);
                last_a = e.data;
            end
        end else begin
            chk("a_idle_valid", a_vo, 0);
            chk("a_idle_done", a_fd, 0);
            chk("a_hold", a_out, last_a);
        end
        if (a_vo) begin
            if (pulses_a == cap_idx) cap_val = a_out;
            pulses_a++;
        end
        if (a_fd) dones_a++;
        if (pend_b) begin
            chk("b_valid", b_vo, 1);
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_data", b_out, e.data);
                chk("b_done", b_fd, e.done);
                last_b = e.data;
            end
        end else begin
            chk("b_idle_valid", b_vo, 0);
            chk("b_idle_done", b_fd, 0);
            chk("b_hold", b_out, last_b);
        end
        if (b_vo) pulses_b++;
        if (b_fd) dones_b++;
        pend_a = 1'b0;
        pend_b = 1'b0;
        a_v = 1'b0;
        b_v = 1'b0;
    endtask

    task automatic clear_counts();
        pulses_a = 0; pulses_b = 0; dones_a = 0; dones_b = 0;
    endtask

    // Stream one frame (or its first max_beats beats) into DUT sel (0 = a, 1 = b).
    task automatic stream(int sel, int w, int h, int mode, int hr, int hc, int hch,
                          int gap_pct, int max_beats);
        exp_t e;
        int   n;
        n = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (n >= max_beats) return;
                for (int g = 0; g < 8 && int'($urandom_range(99)) < gap_pct; g++) step();
                if (sel == 0) begin
                    a_in = pix(mode, hr, hc, hch, r, c);
                    a_v  = 1'b1;
                end else begin
                    b_in = pix(mode, hr, hc, hch, r, c);
                    b_v  = 1'b1;
                end
                if (r % 2 == 1 && c % 2 == 1 && r < 2*(h/2) && c < 2*(w/2)) begin
                    e.data = pooled(mode, hr, hc, hch, r/2, c/2);
                    e.done = (r == 2*(h/2) - 1) && (c == 2*(w/2) - 1);
                    if (sel == 0) begin
                        qa.push_back(e);
                        pend_a = 1'b1;
                    end else begin
                        qb.push_back(e);
                        pend_b = 1'b1;
                    end
                end
                step();
                n++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        a_in = '0; b_in = '0; a_v = 1'b0; b_v = 1'b0;
        pend_a = 1'b0; pend_b = 1'b0;
        last_a = 8'h00; last_b = 8'h00;
        cap_idx = -1; cap_val = 8'h00;
        clear_counts();
        repeat (3) step();
        rst = 1'b0;
        step();

        // Single-hot frame, then the four quadrant positions of window (0,0).
        tbl[0] = '{4, 7, 0, 2, 3, 8'h01};
        tbl[1] = '{0, 0, 0, 0, 0, 8'h01};
        tbl[2] = '{0, 1, 0, 0, 0, 8'h01};
        tbl[3] = '{1, 0, 0, 0, 0, 8'h01};
        tbl[4] = '{1, 1, 0, 0, 0, 8'h01};
        for (int i = 0; i < 5; i++) begin
            clear_counts();
            cap_idx = tbl[i].pr * (W/2) + tbl[i].pc;
            cap_val = 8'hXX;
            stream(0, W, H, 0, tbl[i].hr, tbl[i].hc, tbl[i].hch, 0, W*H);
            chk("tbl_pulses", pulses_a, 169);
            chk("tbl_dones", dones_a, 1);
            chk("tbl_pixel", cap_val, tbl[i].exp);
        end

        // All-ones frame with random input gaps.
        clear_counts();
        stream(0, W, H, 1, 0, 0, 0, 50, W*H);
        chk("gap_pulses", pulses_a, 169);
        chk("gap_dones", dones_a, 1);

        // Reset after 300 beats, then a clean frame with channel 7 only at (25,25).
        stream(0, W, H, 1, 0, 0, 0, 0, 300);
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_counts();
        cap_idx = 168;
        cap_val = 8'hXX;
        stream(0, W, H, 0, 25, 25, 7, 0, W*H);
        chk("rst_pulses", pulses_a, 169);
        chk("rst_dones", dones_a, 1);
        chk("rst_last_pixel", cap_val, 8'h80);

        // Back-to-back frames: all ones then channel-3 checkerboard, no idle cycle.
        stream(0, W, H, 1, 0, 0, 0, 0, W*H);
        clear_counts();
        cap_idx = 0;
        cap_val = 8'hXX;
        stream(0, W, H, 2, 0, 0, 0, 0, W*H);
        chk("b2b_pulses", pulses_a, 169);
        chk("b2b_first", cap_val, 8'h08);

        // 5x5 instance: two all-ones frames, trailing column/row ignored.
        clear_counts();
        stream(1, SW, SH, 1, 0, 0, 0, 0, SW*SH);
        chk("small_pulses_f1", pulses_b, 4);
        stream(1, SW, SH, 1, 0, 0, 0, 0, SW*SH);
        chk("small_pulses_f2", pulses_b, 8);
        chk("small_dones", dones_b, 2);

        repeat (2) step();
        chk("queue_a_empty", qa.size(), 0);
        chk("queue_b_empty", qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
